// File: rtl/botones_pkg.sv
// Shared definitions for the button conditioning chain.
// Holds the FSM encoding, the 50 MHz default timings and a small helper for sizing counters.
package botones_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT_GAP   = 3'd3,
        RELEASE_WAIT = 3'd4
    } estado_t;

    // 50 MHz timings: 10 ms debounce, 0.5 s first repeat, 0.2 s later repeats
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int unsigned REPEAT_DELAY_DEF    = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10_000_000;
    localparam bit          REPEAT_EN_DEF       = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Latency: 2 clk edges from d to q; no backpressure. Both stages reset to RST_VAL.
module sincronizador_2ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/boton_antirrebote.sv
// Push-button conditioner: sync, press/release debounce, optional auto-repeat; out_n is active-low.
// Press latency: 1 + DEBOUNCE_CYCLES edges after btn_n is first sampled low; no backpressure.
module boton_antirrebote
    import botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit          REPEAT_EN       = REPEAT_EN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic out_n,
    output logic press_pulse,
    output logic held
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int          CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic s2;

    sincronizador_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_n),
        .q     (s2)
    );

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_rep_q, first_rep_d;
    logic          out_n_q, out_n_d;
    logic          press_pulse_q, press_pulse_d;
    logic          held_q, held_d;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] rep_last;

    // Saturating increment: with repeat disabled a long hold must not wrap the counter
    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    assign rep_last = first_rep_q ? DLY_LAST : PER_LAST;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        first_rep_d   = first_rep_q;
        out_n_d       = out_n_q;
        press_pulse_d = 1'b0;
        held_d        = held_q;

        case (state_q)
            IDLE: begin
                out_n_d = 1'b1;
                held_d  = 1'b0;
                if (!s2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    out_n_d       = 1'b0;
                    press_pulse_d = 1'b1;
                    held_d        = 1'b1;
                    first_rep_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                out_n_d = 1'b0;
                if (s2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN && (cnt_q == rep_last)) begin
                    state_d       = REPEAT_GAP;
                    cnt_d         = '0;
                    out_n_d       = 1'b1;
                    press_pulse_d = 1'b1;
                    first_rep_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REPEAT_GAP: begin
                // The input is ignored here; a release is picked up by HELD next cycle
                state_d = HELD;
                cnt_d   = '0;
                out_n_d = 1'b0;
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    out_n_d = 1'b1;
                    held_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                out_n_d = 1'b1;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            first_rep_q   <= 1'b1;
            out_n_q       <= 1'b1;
            press_pulse_q <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            first_rep_q   <= first_rep_d;
            out_n_q       <= out_n_d;
            press_pulse_q <= press_pulse_d;
            held_q        <= held_d;
        end
    end

    assign out_n       = out_n_q;
    assign press_pulse = press_pulse_q;
    assign held        = held_q;

endmodule
